spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
Shares one SPI byte engine between NUM_REQ requesters. The engine has a single-cycle start pulse, an active-low enable output, and an 8-bit receive register. Each requester owns one slave chip-select. The block arbitrates round-robin at burst granularity and holds the winner's chip-select low for a multi-byte burst. It sequences one engine byte transfer per accepted byte, returns the received byte to the owner, and enforces chip-select setup/gap timing plus an engine watchdog.

Parameters:
NUM_REQ, 4, number of requesters and chip-selects (2..8)
CS_SETUP, 2, clk cycles cs_n is low before the first byte of a burst (0 allowed)
CS_GAP, 4, clk cycles all cs_n are high after a burst before the next grant (minimum 1)
TIMEOUT, 1024, clk cycles allowed in each engine-wait state before abort

Ports:
clk  in  1  system clock
rst  in  1  reset
req_valid  in  NUM_REQ  requester i has a byte to send
req_last  in  NUM_REQ  requester i's byte is the last of its burst
req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
req_ready  out  NUM_REQ  one-cycle pulse: requester i's byte accepted
rsp_valid  out  NUM_REQ  one-cycle pulse: rsp_data belongs to requester i
rsp_data  out  8  received byte (shared bus)
eng_start  out  1  start pulse to byte engine
eng_data  out  8  byte to engine
eng_en_n  in  1  engine active-low enable (low = transfer in progress)
eng_rx_data  in  8  engine received byte, valid once eng_en_n returns high
cs_n  out  NUM_REQ  active-low chip-selects, at most one low
busy  out  1  high in any state except IDLE
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All state updates happen on the rising edge of clk. The engine shares the same rst.
- Reset values: cs_n all 1; eng_start 0; eng_data 0; req_ready 0; rsp_valid 0; rsp_data 0; busy 0; timeout_err 0; rr pointer 0; state IDLE.
- States: IDLE, SETUP, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD, GAP.
- IDLE:
  - If any req_valid, pick the first asserted index scanning from ptr upward, wrapping modulo NUM_REQ, and latch it as g.
  - cs_n[g] goes low on the next cycle.
  - Next state is SETUP if CS_SETUP>0, else LAUNCH.
- SETUP: stay exactly CS_SETUP cycles, then LAUNCH.
- LAUNCH:
  - Exactly one cycle.
  - eng_start=1, eng_data=req_data[g], req_ready[g]=1.
  - Latch req_last[g]. Next state WAIT_BUSY.
- Latency: req_valid sampled in IDLE at cycle t gives cs_n low at t+1 and eng_start at t+1+CS_SETUP.
- WAIT_BUSY: wait for eng_en_n==0 (nominally the next cycle), then WAIT_DONE.
- WAIT_DONE:
  - On the first cycle eng_en_n==1, capture eng_rx_data into rsp_data.
  - Pulse rsp_valid[g] on the following cycle, in which rsp_data is valid.
  - Then: if the latched last flag is set, go to GAP; else if req_valid[g], go to LAUNCH; else go to HOLD.
- HOLD: cs_n[g] stays low with no time limit. Go to LAUNCH when req_valid[g]==1.
- GAP:
  - All cs_n high for exactly CS_GAP cycles.
  - ptr=(g+1) mod NUM_REQ, updated on GAP entry.
  - Then IDLE.
- Watchdog: a counter of width clog2(TIMEOUT+1) clears on entry to WAIT_BUSY and to WAIT_DONE. If it reaches TIMEOUT:
  - timeout_err pulses for one cycle;
  - no rsp_valid is issued;
  - the state goes to GAP (burst aborted, ptr advances).
- Non-granted requesters are never acknowledged during a burst. Their req_valid changes are ignored until IDLE.
- Changes to req_data[g] or req_last[g] after the LAUNCH cycle have no effect on the current byte.
- rst asserted mid-burst: all outputs return to reset values on the next edge, and any partial rsp is discarded.
- Invariant: cs_n is never low for more than one index; a checker asserts $countones(~cs_n)<=1.

Decomposition:
- Package spi_ctrl_pkg holds the state enum spi_arb_state_t and localparams for default CS_SETUP, CS_GAP and TIMEOUT.
- One sub-module, spi_rr_pick: purely combinational. Inputs are the request vector and ptr; outputs are a one-hot grant and a grant index.

Test Plan:
- Single request: req_valid[1]=1, req_last[1]=1, data 8'hA5, engine model returns 8'h3C → cs_n=4'b1101 two cycles before eng_start; eng_data=A5; rsp_valid[1] with rsp_data=3C; then cs_n=4'b1111 for 4 cycles.
- 3-byte burst from requester 2 (data 01,02,03, last on 03) → cs_n[2] low continuously across all three transfers; three req_ready and three rsp_valid pulses on index 2 only.
- All four requesters asserting single-byte requests continuously from reset → grant order 0,1,2,3,0; each burst separated by at least CS_GAP high cycles.
- Requester 0 drops req_valid after byte 1 of a burst for 20 cycles → HOLD, cs_n[0] stays low, no timeout; resumes with LAUNCH on reassert.
- Engine model never lowers eng_en_n → timeout_err pulse exactly TIMEOUT cycles after WAIT_BUSY entry, no rsp_valid, cs_n all high, next grant goes to the next index.
- rst asserted while in WAIT_DONE → next cycle all outputs at reset values; a subsequent request from requester 0 is granted first (ptr reset to 0).

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and default timing constants for the SPI engine arbiter.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_HOLD,
        ST_GAP
    } spi_arb_state_t;

    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_GAP   = 4;
    localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module spi_rr_pick import spi_ctrl_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int PW = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the closest match to i_ptr wins last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            logic [PW-1:0] w_j;
            w_j = PW'((32'(i_ptr) + k - 1) % NUM_REQ);
            if (i_req[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin burst arbiter sharing one SPI byte engine among NUM_REQ chip-selected requesters.
module spi_arbiter import spi_ctrl_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_GAP   = DEF_CS_GAP,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 eng_start,
    output logic [7:0]           eng_data,
    input  logic                 eng_en_n,
    input  logic [7:0]           eng_rx_data,
    output logic [NUM_REQ-1:0]   cs_n,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int TMAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int WW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP - 1);
    localparam logic [WW-1:0] WD_LIMIT   = WW'(TIMEOUT);

    spi_arb_state_t     r_state, w_next;
    logic [PW-1:0]      r_g, r_ptr, w_pick_idx, w_ptr_next;
    logic [NUM_REQ-1:0] r_g_oh, w_pick_oh;
    logic               r_last;
    logic [TW-1:0]      r_tmr;
    logic [WW-1:0]      r_wd;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [7:0]         r_rsp_data;
    logic               w_in_wait, w_wd_exp;

    spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx)
    );

    assign w_in_wait  = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
    assign w_wd_exp   = w_in_wait && (r_wd == WD_LIMIT);
    assign w_ptr_next = (r_g == PW'(NUM_REQ - 1)) ? '0 : r_g + PW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (|req_valid) w_next = (CS_SETUP > 0) ? ST_SETUP : ST_LAUNCH;
            ST_SETUP:     if (r_tmr == SETUP_LAST) w_next = ST_LAUNCH;
            ST_LAUNCH:    w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (w_wd_exp)       w_next = ST_GAP;
                else if (!eng_en_n) w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_wd_exp)            w_next = ST_GAP;
                else if (eng_en_n) begin
                    if (r_last)          w_next = ST_GAP;
                    else if (req_valid[r_g]) w_next = ST_LAUNCH;
                    else                 w_next = ST_HOLD;
                end
            end
            ST_HOLD:      if (req_valid[r_g]) w_next = ST_LAUNCH;
            ST_GAP:       if (r_tmr == GAP_LAST) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n        = '1;
        eng_start   = 1'b0;
        eng_data    = '0;
        req_ready   = '0;
        busy        = (r_state != ST_IDLE);
        timeout_err = w_wd_exp;
        rsp_valid   = r_rsp_valid;
        rsp_data    = r_rsp_data;
        if (r_state inside {ST_SETUP, ST_LAUNCH, ST_WAIT_BUSY, ST_WAIT_DONE, ST_HOLD}) begin
            cs_n = ~r_g_oh;
        end
        if (r_state == ST_LAUNCH) begin
            eng_start = 1'b1;
            eng_data  = req_data[{r_g, 3'b000} +: 8];
            req_ready = r_g_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_g         <= '0;
            r_g_oh      <= '0;
            r_ptr       <= '0;
            r_last      <= 1'b0;
            r_tmr       <= '0;
            r_wd        <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= '0;
            if (r_state == ST_IDLE && |req_valid) begin
                r_g    <= w_pick_idx;
                r_g_oh <= w_pick_oh;
            end
            if (r_state == ST_LAUNCH) r_last <= req_last[r_g];
            if (w_next == ST_GAP && r_state != ST_GAP) r_ptr <= w_ptr_next;
            // Response is registered so rsp_valid lands one cycle after capture, in whatever state follows.
            if (r_state == ST_WAIT_DONE && !w_wd_exp && eng_en_n) begin
                r_rsp_valid <= r_g_oh;
                r_rsp_data  <= eng_rx_data;
            end
            if (w_next != r_state)                            r_tmr <= '0;
            else if (r_state == ST_SETUP || r_state == ST_GAP) r_tmr <= r_tmr + TW'(1);
            if (w_next != r_state) r_wd <= '0;
            else if (w_in_wait)    r_wd <= r_wd + WW'(1);
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with a behavioural byte engine and requester queues.
module tb_spi_arbiter;

    localparam int N       = 4;
    localparam int SETUP   = 2;
    localparam int GAP     = 4;
    localparam int TMO     = 1024;
    localparam int ENG_LEN = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_last, req_ready, rsp_valid, cs_n;
    logic [8*N-1:0] req_data;
    logic [7:0]     rsp_data, eng_data, eng_rx_data;
    logic           eng_start, eng_en_n, busy, timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    spi_arbiter #(.NUM_REQ(N), .CS_SETUP(SETUP), .CS_GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .eng_start(eng_start), .eng_data(eng_data), .eng_en_n(eng_en_n), .eng_rx_data(eng_rx_data),
        .cs_n(cs_n), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Byte engine: busy for ENG_LEN+1 cycles after start, returns tx byte XOR 8'h99.
    logic eng_hang = 1'b0;
    int   ecnt;
    always @(posedge clk) begin
        if (rst) begin
            eng_en_n    <= 1'b1;
            ecnt        <= 0;
            eng_rx_data <= '0;
        end else if (eng_start && !eng_hang && eng_en_n) begin
            eng_en_n    <= 1'b0;
            ecnt        <= ENG_LEN;
            eng_rx_data <= eng_data ^ 8'h99;
        end else if (!eng_en_n) begin
            if (ecnt == 0) eng_en_n <= 1'b1;
            else           ecnt     <= ecnt - 1;
        end
    end

    logic [8:0]   txq [N][$];
    logic [N-1:0] pop_pend;
    logic [N-1:0] prev_cs;
    int           cyc, hi_run, gap_cycles;
    int           start_cyc[$], ready_idx[$], rsp_idx[$], grant_idx[$], grant_cyc[$], grant_hirun[$], tmo_cyc[$];
    logic [7:0]   start_dat[$], rsp_dat[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor at negedge, requester drive at posedge+1.
    initial begin
        logic [8:0] e;
        req_valid = '0; req_last = '0; req_data = '0;
        pop_pend = '0; prev_cs = '1; hi_run = 0; cyc = 0; gap_cycles = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_cs  = '1;
                hi_run   = 0;
                pop_pend = '0;
            end else begin
                chk("cs_onehot", 32'($countones(~cs_n) <= 1), 1);
                if (eng_start) begin
                    start_cyc.push_back(cyc);
                    start_dat.push_back(eng_data);
                end
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        ready_idx.push_back(i);
                        pop_pend[i] = 1'b1;
                    end
                    if (rsp_valid[i]) begin
                        rsp_idx.push_back(i);
                        rsp_dat.push_back(rsp_data);
                    end
                end
                if (timeout_err) tmo_cyc.push_back(cyc);
                if (busy && cs_n == '1) gap_cycles++;
                if (prev_cs == '1 && cs_n != '1) begin
                    grant_idx.push_back(idx_of(~cs_n));
                    grant_cyc.push_back(cyc);
                    grant_hirun.push_back(hi_run);
                end
                hi_run  = (cs_n == '1) ? hi_run + 1 : 0;
                prev_cs = cs_n;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop_pend[i]) begin
                    if (txq[i].size() != 0) void'(txq[i].pop_front());
                    pop_pend[i] = 1'b0;
                end
                if (txq[i].size() != 0) begin
                    e = txq[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = e[7:0];
                    req_last[i]        = e[8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = '0;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        start_cyc.delete(); start_dat.delete(); ready_idx.delete(); rsp_idx.delete(); rsp_dat.delete();
        grant_idx.delete(); grant_cyc.delete(); grant_hirun.delete(); tmo_cyc.delete();
        gap_cycles = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) txq[i].delete();
        step(3);
        rst = 1'b0;
        clear_logs();
    endtask

    function automatic int count_of(input int which);
        case (which)
            0:       return rsp_idx.size();
            1:       return grant_idx.size();
            2:       return tmo_cyc.size();
            default: return start_cyc.size();
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int n, input int lim, input string tag);
        int k = 0;
        while (count_of(which) < n && k < lim) begin
            step(1);
            k++;
        end
        chk(tag, 32'(count_of(which) >= n), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_limit: got still running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] exp_b [3];
        int hold_low, k;
        exp_b[0] = 8'h98; exp_b[1] = 8'h9B; exp_b[2] = 8'h9A;

        // Reset values
        step(3);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_data", eng_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        clear_logs();

        // Single-byte request from requester 1
        txq[1].push_back({1'b1, 8'hA5});
        wait_cnt(0, 1, 60, "t1_rsp_seen");
        step(8);
        chk("t1_grant", (grant_idx.size() > 0) ? grant_idx[0] : -1, 1);
        chk("t1_cs_lead", (start_cyc.size() > 0 && grant_cyc.size() > 0) ? start_cyc[0] - grant_cyc[0] : -1, SETUP);
        chk("t1_eng_data", (start_dat.size() > 0) ? start_dat[0] : 8'h00, 8'hA5);
        chk("t1_ready_cnt", ready_idx.size(), 1);
        chk("t1_rsp_idx", (rsp_idx.size() > 0) ? rsp_idx[0] : -1, 1);
        chk("t1_rsp_data", (rsp_dat.size() > 0) ? rsp_dat[0] : 8'h00, 8'h3C);
        chk("t1_gap_len", gap_cycles, GAP);
        chk("t1_idle", busy, 0);

        // Three-byte burst from requester 2
        do_reset();
        txq[2].push_back({1'b0, 8'h01});
        txq[2].push_back({1'b0, 8'h02});
        txq[2].push_back({1'b1, 8'h03});
        wait_cnt(0, 3, 150, "t2_rsp_seen");
        step(8);
        chk("t2_one_grant", grant_idx.size(), 1);
        chk("t2_grant", (grant_idx.size() > 0) ? grant_idx[0] : -1, 2);
        chk("t2_ready_cnt", ready_idx.size(), 3);
        chk("t2_rsp_cnt", rsp_idx.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ready_idx.size()) chk("t2_ready_idx", ready_idx[i], 2);
            if (i < rsp_idx.size()) begin
                chk("t2_rsp_idx", rsp_idx[i], 2);
                chk("t2_rsp_data", rsp_dat[i], exp_b[i]);
            end
        end

        // All requesters contending, single-byte bursts
        do_reset();
        for (int i = 0; i < N; i++) begin
            txq[i].push_back({1'b1, 8'(8'h10 + i)});
            txq[i].push_back({1'b1, 8'(8'h20 + i)});
        end
        wait_cnt(1, 5, 300, "t3_grants_seen");
        for (int i = 0; i < 5 && i < grant_idx.size(); i++) begin
            chk("t3_order", grant_idx[i], i % N);
            if (i > 0) chk("t3_gap_min", 32'(grant_hirun[i] >= GAP), 1);
        end

        // HOLD while requester 0 pauses mid-burst
        do_reset();
        txq[0].push_back({1'b0, 8'h11});
        wait_cnt(0, 1, 60, "t4_rsp1_seen");
        step(2);
        hold_low = 0;
        repeat (20) begin
            step(1);
            if (cs_n[0] == 1'b0 && busy) hold_low++;
        end
        chk("t4_hold_low", hold_low, 20);
        chk("t4_hold_no_tmo", tmo_cyc.size(), 0);
        chk("t4_hold_no_launch", start_cyc.size(), 1);
        txq[0].push_back({1'b1, 8'h22});
        wait_cnt(0, 2, 60, "t4_rsp2_seen");
        step(8);
        chk("t4_byte2", (start_dat.size() > 1) ? start_dat[1] : 8'h00, 8'h22);
        chk("t4_rsp2_data", (rsp_dat.size() > 1) ? rsp_dat[1] : 8'h00, 8'hBB);
        chk("t4_one_grant", grant_idx.size(), 1);

        // Engine never responds: watchdog abort
        do_reset();
        eng_hang = 1'b1;
        txq[1].push_back({1'b1, 8'h5A});
        wait_cnt(2, 1, TMO + 100, "t5_tmo_seen");
        chk("t5_cs_high", cs_n, 4'hF);
        chk("t5_tmo_delay", (tmo_cyc.size() > 0 && start_cyc.size() > 0) ? tmo_cyc[0] - (start_cyc[0] + 1) : -1, TMO);
        step(8);
        chk("t5_no_rsp", rsp_idx.size(), 0);
        chk("t5_tmo_pulses", tmo_cyc.size(), 1);
        eng_hang = 1'b0;
        txq[1].push_back({1'b1, 8'h66});
        txq[3].push_back({1'b1, 8'h77});
        wait_cnt(1, 2, 100, "t5_regrant_seen");
        chk("t5_next_grant", (grant_idx.size() > 1) ? grant_idx[1] : -1, 3);
        wait_cnt(0, 2, 200, "t5_rsp_seen");
        chk("t5_rsp0_idx", (rsp_idx.size() > 0) ? rsp_idx[0] : -1, 3);
        chk("t5_rsp0_data", (rsp_dat.size() > 0) ? rsp_dat[0] : 8'h00, 8'hEE);
        chk("t5_rsp1_data", (rsp_dat.size() > 1) ? rsp_dat[1] : 8'h00, 8'hFF);

        // Reset while in WAIT_DONE
        do_reset();
        txq[1].push_back({1'b1, 8'hC3});
        wait_cnt(0, 1, 60, "t6_pre_rsp_seen");
        k = 0;
        while (busy && k < 40) begin
            step(1);
            k++;
        end
        chk("t6_pre_idle", busy, 0);
        txq[3].push_back({1'b1, 8'h44});
        k = 0;
        while (eng_en_n !== 1'b0 && k < 60) begin
            step(1);
            k++;
        end
        chk("t6_eng_busy_seen", eng_en_n, 0);
        step(1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) txq[i].delete();
        step(1);
        chk("t6_cs_n", cs_n, 4'hF);
        chk("t6_eng_start", eng_start, 0);
        chk("t6_eng_data", eng_data, 0);
        chk("t6_req_ready", req_ready, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_data", rsp_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_timeout", timeout_err, 0);
        step(1);
        rst = 1'b0;
        clear_logs();
        step(15);
        chk("t6_rsp_discarded", rsp_idx.size(), 0);
        txq[0].push_back({1'b1, 8'h10});
        txq[3].push_back({1'b1, 8'h30});
        wait_cnt(1, 1, 60, "t6_grant_seen");
        chk("t6_first_grant", (grant_idx.size() > 0) ? grant_idx[0] : -1, 0);
        step(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
